// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers.
// Ports: i_clk/i_reset (sync, active-high); i_req_valid/i_req_data per-requester
// byte offers; o_req_ready one-hot accept pulse; o_tx_transmit/o_tx_data drive the
// transmitter; o_busy marks a frame slot; o_grant_id is the last granted index.
// Build option TX_ARB_FIXED_PRI_EN selects fixed priority (lowest index wins)
// instead of the default round-robin.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_tx_transmit,
    output logic [7:0]           o_tx_data,
    output logic                 o_busy,
    output logic [2:0]           o_grant_id
);
    localparam int CW = $clog2(CLKS_PER_BIT * FRAME_BITS);
    localparam logic [CW-1:0] START_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FRAME_END = CW'(CLKS_PER_BIT * FRAME_BITS - 1);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_req_ready, w_req_ready_nxt;
    logic             r_tx_transmit, w_tx_transmit_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_busy, w_busy_nxt;
    logic [2:0]       r_grant_id, w_grant_id_nxt;
    logic [2:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [N_REQ-1:0] w_rot;
    logic [2:0]       w_off;
    logic [3:0]       w_sum;
    logic [2:0]       w_win;
    logic [2:0]       w_after;
    // Rotate requests so bit 0 is the rr_ptr requester; the first set bit is
    // then the winner's offset from rr_ptr. In the fixed-priority build rr_ptr
    // stays 0, so this reduces to lowest-index-wins.
    always_comb begin
        w_rot = (i_req_valid >> r_rr_ptr) | (i_req_valid << (4'(N_REQ) - {1'b0, r_rr_ptr}));
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = 3'(k);
        w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_win   = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
        w_after = (r_grant_id == 3'(N_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_req_ready   <= '0;
            r_tx_transmit <= 1'b0;
            r_tx_data     <= '0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_tx_transmit <= w_tx_transmit_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_busy        <= w_busy_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_req_ready_nxt   = '0;
        w_tx_transmit_nxt = r_tx_transmit;
        w_tx_data_nxt     = r_tx_data;
        w_busy_nxt        = r_busy;
        w_grant_id_nxt    = r_grant_id;
        w_rr_ptr_nxt      = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (|i_req_valid) begin
                    w_req_ready_nxt   = N_REQ'(1) << w_win;
                    w_tx_data_nxt     = i_req_data[8*w_win +: 8];
                    w_grant_id_nxt    = w_win;
                    w_busy_nxt        = 1'b1;
                    w_tx_transmit_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = START;
                end
            end
            START: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == START_END) begin
                    w_tx_transmit_nxt = 1'b0;
                    w_state_nxt       = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == FRAME_END) begin
                    w_busy_nxt  = 1'b0;
`ifdef TX_ARB_FIXED_PRI_EN
                    w_rr_ptr_nxt = 3'd0;
`else
                    w_rr_ptr_nxt = w_after;
`endif
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    assign o_req_ready   = r_req_ready;
    assign o_tx_transmit = r_tx_transmit;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant_id;
endmodule
